// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Serial console transmitter. Bytes enter a small FIFO through a
//   valid/ready handshake. Each byte then leaves on tx_o as an 8N1 frame:
//   one start bit, eight data bits LSB first, and one stop bit.
//
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous, active high; flushes the FIFO and aborts any frame
//   data_i   : byte to enqueue
//   valid_i  : data_i is valid this cycle
//   ready_o  : FIFO not full (driven only by the registered count)
//   tx_o     : registered serial line, idle high
//   busy_o   : transmitter active or bytes still queued
//   count_o  : number of queued bytes

module uart_tx_fifo #(
    parameter int CLOCK_HZ = 625,
    parameter int BAUD     = 78,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int DIV = CLOCK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV >= 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: CLOCK_HZ/BAUD must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            push;
    logic            pop;
    logic            bit_done;

    // ready_o does not look ahead at a same-cycle pop, so a full FIFO
    // refuses a push even on the edge that frees an entry.
    assign ready_o  = (count != CW'(DEPTH));
    assign push     = valid_i && ready_o;
    assign pop      = (state == IDLE) && (count != '0);
    assign bit_done = (baud_cnt == BW'(DIV - 1));
    assign busy_o   = (state != IDLE) || (count != '0);
    assign count_o  = count;

    // Storage is left unreset; the flushed pointers and count make old
    // contents unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);

            // tx_o is loaded with the level of the state or bit being
            // entered, so every line transition lands on that edge.
            case (state)
                IDLE: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + AW'(1);
                        tx_o   <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_o     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // shift[1] is the next bit once this shift lands.
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo at default parameters (DIV = 8, DEPTH = 4).
//   A line monitor decodes every frame on tx_o and compares it with the
//   queue of accepted bytes. Table vectors check single frames bit by bit;
//   hand-written sequences cover back-to-back frames, a full FIFO, a
//   mid-frame reset and a push on the pop edge.

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo dut (
        .clk     (clk),
        .reset   (reset),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 2000) begin
            step();
            n++;
        end
        check("idle_timeout", busy_o, 0);
    endtask

    // Line monitor: detects a start bit, samples mid-bit and compares the
    // decoded byte against the oldest accepted byte.
    initial begin
        logic       prev_tx = 1'b1;
        logic       mon_busy = 1'b0;
        int         t = 0;
        logic [7:0] rx = 8'h00;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (prev_tx === 1'b1 && tx_o === 1'b0) begin
                    mon_busy = 1'b1;
                    t = 0;
                end
            end else begin
                t++;
                if (t == 4)
                    check("mon_start_bit", tx_o, 0);
                if (t >= 12 && t <= 68 && (t % 8) == 4)
                    rx[(t - 12) / 8] = tx_o;
                if (t == 76) begin
                    check("mon_stop_bit", tx_o, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected_frame: got %0h expected none", rx);
                    end else begin
                        exp = exp_q.pop_front();
                        check("mon_data", rx, exp);
                    end
                    mon_busy = 1'b0;
                end
            end
            prev_tx = tx_o;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line levels, bit 0 first on the wire
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc;
        int first_low;
        int n;

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
        vecs[4] = '{8'h5A, 10'b1_0101_1010_0};

        // Reset defaults
        reset = 1'b1;
        repeat (3) step();
        check("rst_tx", tx_o, 1);
        check("rst_count", count_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_tx", tx_o, 1);
            check("idle_ready", ready_o, 1);
            check("idle_count", count_o, 0);
            check("idle_busy", busy_o, 0);
        end

        // Single frames, checked bit by bit from the table
        for (int v = 0; v < 5; v++) begin
            data_i  = vecs[v].data;
            valid_i = 1'b1;
            step();                              // edge N: push
            exp_q.push_back(vecs[v].data);
            valid_i = 1'b0;
            check("vec_count_push", count_o, 1);
            check("vec_busy_push", busy_o, 1);
            step();                              // edge N+1: pop, start bit
            check("vec_count_pop", count_o, 0);
            for (int c = 0; c < 80; c++) begin
                if (c == 0)
                    check("vec_start_edge", tx_o, 0);
                if ((c % 8) == 4)
                    check("vec_bit", tx_o, vecs[v].frame[c / 8]);
                if (c == 79)
                    check("vec_stop_end", tx_o, 1);
                step();
            end
            check("vec_busy_end", busy_o, 0);   // N+81
            check("vec_tx_end", tx_o, 1);
        end
        check("vec_q_empty", exp_q.size(), 0);

        // Back-to-back frames
        valid_i = 1'b1;
        data_i  = 8'h00;
        step();
        exp_q.push_back(8'h00);
        check("b2b_count0", count_o, 1);
        data_i = 8'hFF;
        step();
        exp_q.push_back(8'hFF);
        check("b2b_count1", count_o, 1);
        check("b2b_start1", tx_o, 0);
        data_i = 8'h55;
        step();
        exp_q.push_back(8'h55);
        check("b2b_count2", count_o, 2);
        valid_i = 1'b0;
        repeat (79) step();                      // N+81
        check("b2b_gap_tx", tx_o, 1);
        check("b2b_gap_count", count_o, 2);
        step();                                  // N+82
        check("b2b_start2", tx_o, 0);
        check("b2b_count3", count_o, 1);
        repeat (80) step();                      // N+162
        check("b2b_gap2_tx", tx_o, 1);
        step();                                  // N+163
        check("b2b_start3", tx_o, 0);
        check("b2b_count4", count_o, 0);
        wait_idle();
        check("b2b_q_empty", exp_q.size(), 0);

        // Full FIFO and pointer wrap
        acc = 0;
        first_low = -1;
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = 8'(8'h10 + i);
            n = 0;
            while (!ready_o && n < 200) begin
                step();
                n++;
            end
            check("full_push_ready", ready_o, 1);
            step();
            exp_q.push_back(data_i);
            acc++;
            if (first_low < 0 && !ready_o) begin
                first_low = acc;
                check("full_count", count_o, 4);
            end
        end
        valid_i = 1'b0;
        check("full_first_low", first_low, 5);
        wait_idle();
        check("full_q_empty", exp_q.size(), 0);

        // Reset during bit 3 of 0x3C with two bytes queued
        valid_i = 1'b1;
        data_i = 8'h3C; step();
        data_i = 8'h11; step();
        data_i = 8'h22; step();                  // N+2
        valid_i = 1'b0;
        check("mid_count", count_o, 2);
        repeat (33) step();                      // N+35, inside bit 3
        check("mid_bit3", tx_o, 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        check("mid_rst_tx", tx_o, 1);
        check("mid_rst_count", count_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", ready_o, 1);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("mid_quiet_tx", tx_o, 1);
        end
        check("mid_quiet_busy", busy_o, 0);
        valid_i = 1'b1;
        data_i = 8'h81;
        step();
        exp_q.push_back(8'h81);
        valid_i = 1'b0;
        wait_idle();
        check("mid_q_empty", exp_q.size(), 0);

        // Push on the pop edge
        valid_i = 1'b1;
        data_i = 8'h5A;
        step();
        exp_q.push_back(8'h5A);
        check("pp_count0", count_o, 1);
        data_i = 8'hC3;
        step();
        exp_q.push_back(8'hC3);
        valid_i = 1'b0;
        check("pp_count1", count_o, 1);
        check("pp_start", tx_o, 0);
        wait_idle();
        check("pp_q_empty", exp_q.size(), 0);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmit stage that sits downstream of the CPU I/O-out register. It accepts bytes over a valid/ready handshake into a small FIFO and shifts each one out as an 8N1 UART frame at the same baud rate the PROM-loading receiver uses. This gives the CPU a serial console path alongside the parallel `io_out` pins.

## Interface

Parameters:
- `CLOCK_HZ`, default 625: input clock frequency.
- `BAUD`, default 78: bit rate.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- Derived `DIV = CLOCK_HZ / BAUD` (integer division): clocks per bit. Defaults give DIV = 8. DIV < 2 is an elaboration error.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `data_i`, input, 8: byte to send.
- `valid_i`, input, 1: `data_i` is valid this cycle.
- `ready_o`, output, 1: FIFO not full. Combinational from the registered count only.
- `tx_o`, output, 1: serial line, registered, idle high.
- `busy_o`, output, 1: high when the transmitter is not IDLE or the FIFO is non-empty.
- `count_o`, output, $clog2(DEPTH)+1: number of FIFO entries.

## Operation

- **Reset values:** `tx_o`=1, `count_o`=0, `ready_o`=1, `busy_o`=0, state IDLE. Read/write pointers, bit counter and baud counter are all 0.
- **Push:** on an edge with `valid_i && ready_o`, write `data_i` at the write pointer. The write pointer wraps modulo DEPTH.
- **Pop:** on an edge in IDLE with count > 0, load the head into the shift register, advance the read pointer (modulo DEPTH) and enter START.
- **Push and pop on the same edge:** count is unchanged and both pointers advance.
- **Full FIFO:** `ready_o`=0 and pushes are ignored. This holds even on a pop edge, because `ready_o` does not look ahead.
- **Empty FIFO:** the transmitter stays in IDLE with `tx_o`=1.
- **State machine** (the baud counter counts 0..DIV-1 within each bit):
  - **IDLE:** `tx_o`=1. On count > 0, pop and go to START.
  - **START:** `tx_o`=0 for DIV cycles, then go to DATA with bit index 0.
  - **DATA:** `tx_o`=shift[0] for DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP. Bits go out LSB first.
  - **STOP:** `tx_o`=1 for DIV cycles, then go to IDLE.
- `tx_o` is registered: each level change lands on the edge that enters the new state or bit.
- **Reset mid-frame:** on the next edge `tx_o` returns to 1 and the FIFO is flushed. The truncated frame is not resent.
- Bytes already queued are unaffected by later pushes. Order is strictly FIFO.

## Timing

- Push accepted at edge N: count=1 after N. Pop at edge N+1, where `tx_o` falls (start bit begins).
- **Frame length:** 10·DIV cycles of line activity, from start-bit falling edge to the end of the stop bit.
- **Back-to-back frames:** the STOP→IDLE edge is followed by one IDLE cycle, then the pop edge. Start bits of consecutive queued bytes are therefore 10·DIV+1 cycles apart (81 at defaults).
- **Throughput:** with DEPTH=4 and a continuous producer, `ready_o` first drops after the 5th accepted byte. That is 4 stored, the first having been popped into the shift register.
- `count_o` and `ready_o` update on the edge of the push or pop. `busy_o` falls on the STOP→IDLE edge when the FIFO is empty.

## Test plan

1. **Reset defaults:** hold `reset` 3 cycles, then release with `valid_i`=0 → `tx_o`=1, `ready_o`=1, `count_o`=0, `busy_o`=0 for 100 cycles.
2. **Single byte:** push 0xA5 at edge N (DIV=8) → `tx_o` from edge N+1 holds, 8 cycles each: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). IDLE and `busy_o`=0 at N+81.
3. **Back-to-back:** push 0x00, 0xFF, 0x55 on consecutive cycles → three correct frames, start bits at N+1, N+82, N+163. `count_o` sequence is 1,1,2 then draining.
4. **Full and wrap:** push 6 bytes 0x10..0x15 continuously with a monitor on `ready_o` → `ready_o`=0 after the 5th; the 6th is held until it is accepted. All 6 are sent in order, exercising pointer wrap past DEPTH-1.
5. **Mid-frame reset:** assert `reset` during bit 3 of 0x3C with 2 bytes queued → `tx_o`=1 next edge, `count_o`=0. No further frames start; a subsequent push of 0x81 transmits correctly.
6. **Push on pop edge:** with count=1 in IDLE, push on the pop edge → `count_o` stays 1 and both bytes go out in order.
